usb_log_rx_mux: RTL
===================

Name: usb_log_rx_mux

Overview:
Multi-channel successor to the single-source USB log packer. It round-robin arbitrates NCH packet-capture FIFO pairs (meta + data) and packs several framed records into one USB bulk IN buffer. The buffer is committed when the next worst-case record will not fit, or when a flush timeout expires. Sits between per-port capture FIFOs and the USB bulk IN endpoint buffer RAM.

Parameters:
NCH, 4, number of source channels (1..16)
META_BYTES, 8, meta word width in bytes (1..16); sent MSB byte first
MAX_DATA, 64, max logged data bytes per record (1..255); excess bytes are drained and discarded
ADDR_W, 9, endpoint buffer address width; BUF_BYTES = 2**ADDR_W
FLUSH_CYCLES, 125000, clock cycles from first record in a buffer to forced commit
CNT_W, 17, flush counter width; must hold FLUSH_CYCLES

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
available  in  NCH  per-channel record pending
meta  in  NCH*META_BYTES*8  channel i at slice i; valid 1 cycle after meta_en[i]
meta_en  out  NCH  one-cycle meta FIFO pop
data  in  NCH*8  channel i at slice i; valid 1 cycle after data_en[i]
data_stop  in  NCH  marks the last data byte of the record, aligned with data
data_en  out  NCH  data FIFO pop
usb_in_addr  out  ADDR_W  buffer write address
usb_in_data  out  8  buffer write data
usb_in_wren  out  1  buffer write strobe
usb_in_ready  in  1  endpoint buffer free
usb_in_commit  out  1  commit request, level
usb_in_commit_len  out  ADDR_W+1  committed byte count
usb_in_commit_ack  in  1  commit acknowledge

Behaviour:
- Reset: all outputs 0. State IDLE, fill=0, rr pointer=0, flush counter cleared. Reset mid-record or mid-commit abandons the partial buffer; no commit is issued.
- usb_in_addr, usb_in_data and usb_in_wren are registered together in the same cycle.
- Record layout at base address B:
  - B+0: {trunc, 3'b0, chan[3:0]}
  - B+1: stored data length L (0..MAX_DATA)
  - B+2..B+1+META_BYTES: meta bytes, MSB first
  - then L data bytes
- Record size = 2 + META_BYTES + L.
- Header bytes are back-patched after the data phase completes.
- Fit rule: RMAX = 2 + META_BYTES + MAX_DATA.
- States and transitions:
  - IDLE: if fill>0 and (flush count reached FLUSH_CYCLES, or fill+RMAX > BUF_BYTES), go to COMMIT. Else if any available bit is set and usb_in_ready is high, grant the first requesting channel at or after rr. Pulse meta_en[g] and go to META_WAIT. A commit condition takes priority over a new grant in the same cycle.
  - META_WAIT: 1 cycle, go to META.
  - META: write META_BYTES bytes at B+2 upward, one per cycle. On the last byte, raise data_en[g] and go to DATA_WAIT.
  - DATA_WAIT: 1 cycle, go to DATA.
  - DATA: hold data_en[g] high every cycle.
    - For each byte: if L<MAX_DATA, write it and increment L; otherwise set trunc and discard the byte.
    - On data_stop[g], drop data_en the same cycle and go to HDR0.
    - data_stop on the first byte gives L=1. There is no zero-length data phase.
  - HDR0: write byte0 at B. HDR1: write L at B+1. Then fill += record size, rr = g+1 mod NCH, go to IDLE.
  - COMMIT: hold usb_in_commit=1 and usb_in_commit_len=fill until usb_in_commit_ack is high, then go to WAIT.
  - WAIT: wait for ack low, then fill=0, flush counter cleared, go to IDLE.
- Flush counter: runs while fill>0 and saturates at FLUSH_CYCLES. It starts counting in the cycle after the first record's HDR1.
- Only one enable bit is ever high at a time. available changes on non-granted channels are ignored until the next IDLE.

Decomposition:
- Package usb_log_pkg holds:
  - state encodings
  - header bit positions (TRUNC_BIT=7, CHAN_LSB=0)
  - HDR_BYTES=2
  - function rec_max(META_BYTES, MAX_DATA)
- One natural sub-module, usb_log_rr_arb (parametrised NCH): round-robin grant from the request vector and rr pointer, with one-hot and index outputs. Purely combinational; rr register lives in the parent.

Test Plan:
- Ch0 only, meta=0x0102030405060708, 3 data bytes AA BB CC with stop on CC, FLUSH_CYCLES=100:
  - RAM[0..12] = 00 03 01 02 03 04 05 06 07 08 AA BB CC
  - commit asserted with len=13 about 100 cycles after the record.
- Ch2, 70 data bytes, MAX_DATA=64:
  - 70 data_en pops consumed
  - RAM[0]=0x82, RAM[1]=0x40, 64 data bytes stored.
- All 4 channels available simultaneously, one record each:
  - grant order 0,1,2,3 with rr=0
  - records packed back-to-back at B=0,13,26,39 for 3-byte records
  - then keep ch1 and ch3 requesting: next grants 1,3,1.
- Repeated 64-byte records (RMAX=74, BUF=512):
  - 6 records written, then commit len=444 before the 7th grant
  - 7th record lands at address 0 after ack falls.
- Hold usb_in_commit_ack low for 20 cycles then high for 3:
  - commit and len stable for the whole interval
  - no grant while usb_in_ready is low.
- Assert reset during the DATA phase:
  - all outputs 0 asynchronously
  - no commit; the next record starts at address 0 with rr=0.

Source files
------------

// File: rtl/usb_log_pkg.sv
// Shared encodings and record-layout constants for the multi-channel USB log packer.
package usb_log_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_META_WAIT,
    ST_META,
    ST_DATA_WAIT,
    ST_DATA,
    ST_HDR0,
    ST_HDR1,
    ST_COMMIT,
    ST_WAIT
  } state_t;

  localparam int TRUNC_BIT = 7;
  localparam int CHAN_LSB  = 0;
  localparam int HDR_BYTES = 2;

  // Worst-case record footprint, used for the buffer fit decision.
  function automatic int rec_max(input int meta_bytes, input int max_data);
    return HDR_BYTES + meta_bytes + max_data;
  endfunction

endpackage

// File: rtl/usb_log_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins.
module usb_log_rr_arb #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  rr_ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_valid
);

  // Scan from the far end so the nearest requester is the last one assigned.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NCH]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'((int'(rr_ptr) + k) % NCH);
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/usb_log_rx_mux.sv
// Packs framed log records from NCH capture FIFO pairs into one USB bulk IN buffer.
//
// state      | meaning
// IDLE       | decide commit or grant next channel
// META_WAIT  | meta pop in flight
// META       | write meta bytes MSB first at B+2..
// DATA_WAIT  | first data pop in flight
// DATA       | stream data bytes until data_stop, truncating past MAX_DATA
// HDR0       | back-patch {trunc, chan} at B
// HDR1       | back-patch length at B+1, advance fill and rr
// COMMIT     | hold commit request until ack
// WAIT       | wait for ack release, then empty the buffer
module usb_log_rx_mux
  import usb_log_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int META_BYTES   = 8,
  parameter int MAX_DATA     = 64,
  parameter int ADDR_W       = 9,
  parameter int FLUSH_CYCLES = 125000,
  parameter int CNT_W        = 17
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NCH-1:0]             available,
  input  logic [NCH*META_BYTES*8-1:0] meta,
  output logic [NCH-1:0]             meta_en,
  input  logic [NCH*8-1:0]           data,
  input  logic [NCH-1:0]             data_stop,
  output logic [NCH-1:0]             data_en,
  output logic [ADDR_W-1:0]          usb_in_addr,
  output logic [7:0]                 usb_in_data,
  output logic                       usb_in_wren,
  input  logic                       usb_in_ready,
  output logic                       usb_in_commit,
  output logic [ADDR_W:0]            usb_in_commit_len,
  input  logic                       usb_in_commit_ack
);

  localparam int IW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MW        = META_BYTES * 8;
  localparam int MCW       = $clog2(META_BYTES + 1);
  localparam int RMAX      = rec_max(META_BYTES, MAX_DATA);
  localparam int BUF_BYTES = 2 ** ADDR_W;

  state_t            state, state_nxt;
  logic [IW-1:0]     g, rr, arb_idx;
  logic [NCH-1:0]    g_oh, arb_gnt;
  logic              arb_valid;
  logic [ADDR_W-1:0] base;
  logic [MCW-1:0]    mcnt;
  logic [7:0]        len;
  logic              trunc;
  logic [ADDR_W:0]   fill;
  logic [CNT_W-1:0]  flush_cnt;

  logic [MW-1:0]     meta_g;
  logic [7:0]        meta_byte, data_g, hdr0;
  logic              stop_g, meta_last, commit_due;

  usb_log_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
    .req       (available),
    .rr_ptr    (rr),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    meta_g     = meta[int'(g)*MW +: MW];
    meta_byte  = meta_g[(META_BYTES - 1 - int'(mcnt))*8 +: 8];
    data_g     = data[int'(g)*8 +: 8];
    stop_g     = data_stop[g];
    meta_last  = (int'(mcnt) == META_BYTES - 1);
    commit_due = (fill != '0) && ((flush_cnt == '0) || (int'(fill) + RMAX > BUF_BYTES));
    hdr0                 = '0;
    hdr0[TRUNC_BIT]      = trunc;
    hdr0[CHAN_LSB +: 4]  = 4'(g);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    meta_en           = '0;
    data_en           = '0;
    usb_in_commit     = 1'b0;
    usb_in_commit_len = '0;
    case (state)
      ST_IDLE: begin
        if (commit_due)                    state_nxt = ST_COMMIT;
        else if (arb_valid && usb_in_ready) state_nxt = ST_META_WAIT;
      end
      ST_META_WAIT: begin
        meta_en   = g_oh;
        state_nxt = ST_META;
      end
      ST_META:      if (meta_last) state_nxt = ST_DATA_WAIT;
      ST_DATA_WAIT: begin
        data_en   = g_oh;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        // Stop byte is the final one, so the pop must not be issued alongside it.
        if (stop_g) state_nxt = ST_HDR0;
        else        data_en   = g_oh;
      end
      ST_HDR0: state_nxt = ST_HDR1;
      ST_HDR1: state_nxt = ST_IDLE;
      ST_COMMIT: begin
        usb_in_commit     = 1'b1;
        usb_in_commit_len = fill;
        if (usb_in_commit_ack) state_nxt = ST_WAIT;
      end
      ST_WAIT: if (!usb_in_commit_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      g           <= '0;
      g_oh        <= '0;
      rr          <= '0;
      base        <= '0;
      mcnt        <= '0;
      len         <= '0;
      trunc       <= 1'b0;
      fill        <= '0;
      flush_cnt   <= CNT_W'(FLUSH_CYCLES);
      usb_in_addr <= '0;
      usb_in_data <= '0;
      usb_in_wren <= 1'b0;
    end else begin
      usb_in_wren <= 1'b0;
      // Down-counter reloads while the buffer is empty; zero means the flush deadline hit.
      if (fill == '0)            flush_cnt <= CNT_W'(FLUSH_CYCLES);
      else if (flush_cnt != '0)  flush_cnt <= flush_cnt - 1'b1;
      case (state)
        ST_IDLE: if (state_nxt == ST_META_WAIT) begin
          g     <= arb_idx;
          g_oh  <= arb_gnt;
          base  <= fill[ADDR_W-1:0];
          mcnt  <= '0;
          len   <= '0;
          trunc <= 1'b0;
        end
        ST_META: begin
          usb_in_addr <= base + ADDR_W'(HDR_BYTES) + ADDR_W'(mcnt);
          usb_in_data <= meta_byte;
          usb_in_wren <= 1'b1;
          mcnt        <= mcnt + 1'b1;
        end
        ST_DATA: begin
          if (int'(len) < MAX_DATA) begin
            usb_in_addr <= base + ADDR_W'(HDR_BYTES + META_BYTES) + ADDR_W'(len);
            usb_in_data <= data_g;
            usb_in_wren <= 1'b1;
            len         <= len + 1'b1;
          end else begin
            trunc <= 1'b1;
          end
        end
        ST_HDR0: begin
          usb_in_addr <= base;
          usb_in_data <= hdr0;
          usb_in_wren <= 1'b1;
        end
        ST_HDR1: begin
          usb_in_addr <= base + ADDR_W'(1);
          usb_in_data <= len;
          usb_in_wren <= 1'b1;
          fill        <= fill + (ADDR_W+1)'(HDR_BYTES + META_BYTES) + (ADDR_W+1)'(len);
          rr          <= (int'(g) == NCH - 1) ? '0 : g + 1'b1;
        end
        ST_WAIT: if (!usb_in_commit_ack) fill <= '0;
        default: ;
      endcase
    end
  end

endmodule
